elevator_shaft: RTL and testbench

Cycle-level behavioural model of the elevator car and shaft, i.e. the plant driven by the elevator controller. It consumes the controller's motor commands (`motor_dir`, `motor_move`) and produces the one-hot floor `sensor` vector the controller reads. It also models a door dwell interlock. The block sits opposite the controller in the system testbench and in FPGA demo builds, closing the control loop without physical hardware.

---
 rtl/elevator_shaft.sv | 140 ++++++++++++++
 tb/tb_elevator_shaft.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/elevator_shaft.sv
// rtl/elevator_shaft.sv - elevator car/shaft plant model driven by motor commands
// Optional door dwell interlock enabled by defining ELEVATOR_SHAFT_DOOR_EN.
module elevator_shaft #(
    parameter int NUM_FLOORS      = 5,
    parameter int TICKS_PER_FLOOR = 8,
    parameter int DOOR_CYCLES     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  motor_dir,
    input  logic                  motor_move,
    output logic [NUM_FLOORS-1:0] sensor,
    output logic [2:0]            floor,
    output logic                  at_floor,
    output logic                  door_open,
    output logic                  overtravel,
    output logic                  interlock_err
);

    localparam int MAX   = (NUM_FLOORS - 1) * TICKS_PER_FLOOR;
    localparam int POS_W = (MAX > 0) ? $clog2(MAX + 1) : 1;
    localparam logic [POS_W-1:0] POS_MAX = POS_W'(MAX);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        DOOR   = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [POS_W-1:0] pos_q, pos_d;
    logic [2:0]       floor_q, floor_d;
    logic             overtravel_q, overtravel_d;
    logic             in_door, block, accept;

`ifdef ELEVATOR_SHAFT_DOOR_EN
    localparam int CNT_W = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;
    logic [CNT_W-1:0] door_cnt_q, door_cnt_d;
    logic             interlock_err_q, interlock_err_d;
`endif

    // Landing decode straight off the registered position.
    always_comb begin
        sensor = '0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            sensor[i] = (pos_q == POS_W'(i * TICKS_PER_FLOOR));
        end
    end

    assign at_floor   = |sensor;
    assign floor      = floor_q;
    assign overtravel = overtravel_q;
    assign in_door    = (state_q == DOOR);

`ifdef ELEVATOR_SHAFT_DOOR_EN
    assign door_open     = in_door;
    assign interlock_err = interlock_err_q;
`else
    assign door_open     = 1'b0;
    assign interlock_err = 1'b0;
`endif

    assign block  = motor_dir ? (pos_q == POS_MAX) : (pos_q == '0);
    assign accept = motor_move && !in_door && !block;

    always_comb begin
        pos_d        = pos_q;
        floor_d      = floor_q;
        state_d      = state_q;
        overtravel_d = overtravel_q | (motor_move && block && !in_door);
`ifdef ELEVATOR_SHAFT_DOOR_EN
        door_cnt_d      = door_cnt_q;
        interlock_err_d = in_door && motor_move;
`endif

        if (accept) begin
            pos_d = motor_dir ? pos_q + POS_W'(1) : pos_q - POS_W'(1);
        end

        // floor tracks the landing the car is about to be level with
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pos_d == POS_W'(i * TICKS_PER_FLOOR)) begin
                floor_d = 3'(i);
            end
        end

        case (state_q)
            IDLE: begin
                if (accept) state_d = MOVING;
            end
            MOVING: begin
                if (accept) begin
                    state_d = MOVING;
                end else if (!motor_move && at_floor) begin
`ifdef ELEVATOR_SHAFT_DOOR_EN
                    state_d    = DOOR;
                    door_cnt_d = CNT_W'(DOOR_CYCLES - 1);
`else
                    state_d = IDLE;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef ELEVATOR_SHAFT_DOOR_EN
            DOOR: begin
                if (door_cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    door_cnt_d = door_cnt_q - CNT_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            pos_q        <= '0;
            floor_q      <= '0;
            overtravel_q <= 1'b0;
`ifdef ELEVATOR_SHAFT_DOOR_EN
            door_cnt_q      <= '0;
            interlock_err_q <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            pos_q        <= pos_d;
            floor_q      <= floor_d;
            overtravel_q <= overtravel_d;
`ifdef ELEVATOR_SHAFT_DOOR_EN
            door_cnt_q      <= door_cnt_d;
            interlock_err_q <= interlock_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_elevator_shaft.sv
// tb/tb_elevator_shaft.sv - directed self-checking bench for elevator_shaft
module tb_elevator_shaft;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       motor_dir = 1'b0;
    logic       motor_move = 1'b0;
    logic [4:0] sensor;
    logic [2:0] floor;
    logic       at_floor;
    logic       door_open;
    logic       overtravel;
    logic       interlock_err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    elevator_shaft dut (
        .clk           (clk),
        .reset         (reset),
        .motor_dir     (motor_dir),
        .motor_move    (motor_move),
        .sensor        (sensor),
        .floor         (floor),
        .at_floor      (at_floor),
        .door_open     (door_open),
        .overtravel    (overtravel),
        .interlock_err (interlock_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sens_at(input int p);
        logic [4:0] s;
        s = '0;
        if (p % 8 == 0) s[p / 8] = 1'b1;
        return s;
    endfunction

    initial begin
        step();
        step();
        check("rst_sensor", 32'(sensor), 32'h01);
        check("rst_floor", 32'(floor), 32'd0);
        check("rst_at_floor", 32'(at_floor), 32'd1);
        check("rst_door", 32'(door_open), 32'd0);
        check("rst_ovt", 32'(overtravel), 32'd0);
        check("rst_ierr", 32'(interlock_err), 32'd0);
        reset = 1'b0;

        motor_dir  = 1'b1;
        motor_move = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("up_f1_sensor", 32'(sensor), 32'(sens_at(k)));
        end
        check("f1_floor", 32'(floor), 32'd1);

`ifdef ELEVATOR_SHAFT_DOOR_EN
        motor_move = 1'b0;
        step();
        check("door_c1", 32'(door_open), 32'd1);
        check("door_c1_ierr", 32'(interlock_err), 32'd0);
        step();
        check("door_c2", 32'(door_open), 32'd1);
        motor_move = 1'b1;
        step();
        check("ierr_pulse", 32'(interlock_err), 32'd1);
        check("ierr_pos_held", 32'(sensor), 32'h02);
        check("door_c3", 32'(door_open), 32'd1);
        motor_move = 1'b0;
        step();
        check("ierr_clear", 32'(interlock_err), 32'd0);
        check("door_c4", 32'(door_open), 32'd1);
        step();
        check("door_closed", 32'(door_open), 32'd0);
        check("door_closed_sensor", 32'(sensor), 32'h02);
        motor_move = 1'b1;
`else
        motor_move = 1'b0;
        step();
        check("nodoor_door", 32'(door_open), 32'd0);
        check("nodoor_sensor", 32'(sensor), 32'h02);
        check("nodoor_floor", 32'(floor), 32'd1);
        motor_move = 1'b1;
`endif
        step();
        check("leave_f1", 32'(sensor), 32'h00);
        check("leave_f1_ierr", 32'(interlock_err), 32'd0);
        check("leave_f1_door", 32'(door_open), 32'd0);

        for (int p = 10; p <= 32; p++) begin
            step();
            check("up_f4_sensor", 32'(sensor), 32'(sens_at(p)));
        end
        check("f4_floor", 32'(floor), 32'd4);
        check("f4_ovt", 32'(overtravel), 32'd0);

        step();
        check("top_block_sensor", 32'(sensor), 32'h10);
        check("top_ovt_set", 32'(overtravel), 32'd1);
        step();
        check("top_block_sensor2", 32'(sensor), 32'h10);
        check("top_ovt_sticky", 32'(overtravel), 32'd1);

        motor_dir = 1'b0;
        step();
        check("reverse_sensor", 32'(sensor), 32'h00);
        check("reverse_floor", 32'(floor), 32'd4);
        check("reverse_ovt", 32'(overtravel), 32'd1);
        for (int p = 30; p >= 16; p--) begin
            step();
            check("down_sensor", 32'(sensor), 32'(sens_at(p)));
        end
        check("down_f2_floor", 32'(floor), 32'd2);

        reset      = 1'b1;
        motor_move = 1'b0;
        step();
        check("rst2_sensor", 32'(sensor), 32'h01);
        check("rst2_floor", 32'(floor), 32'd0);
        check("rst2_ovt", 32'(overtravel), 32'd0);
        reset = 1'b0;

        motor_dir  = 1'b1;
        motor_move = 1'b1;
        for (int k = 1; k <= 13; k++) step();
        motor_move = 1'b0;
        step();
        check("mid_sensor", 32'(sensor), 32'h00);
        check("mid_at_floor", 32'(at_floor), 32'd0);
        check("mid_floor", 32'(floor), 32'd1);
        check("mid_door", 32'(door_open), 32'd0);
        step();
        step();
        check("mid_door_later", 32'(door_open), 32'd0);
        check("mid_sensor_later", 32'(sensor), 32'h00);

        reset = 1'b1;
        step();
        check("rst3_sensor", 32'(sensor), 32'h01);
        check("rst3_at_floor", 32'(at_floor), 32'd1);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
